// File: rtl/sop_logic_eval_pkg.sv
// Shared constants and helpers for the programmable sum-of-products evaluator.
package sop_logic_eval_pkg;

  localparam int unsigned SOP_N_IN   = 4;
  localparam int unsigned SOP_N_TERM = 2;
  localparam int unsigned SOP_CNT_W  = 8;

  // Default masks reproduce (x1&x2 | x3&x4) & (x2&x4)
  localparam logic [SOP_N_TERM*SOP_N_IN-1:0] SOP_DEF_TERM_MASK = 8'hC3;
  localparam logic [SOP_N_IN-1:0]            SOP_DEF_GATE_MASK = 4'hA;

  // Ceiling log2, used to size the config address
  function automatic int unsigned sop_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sop_logic_eval_if.sv
// Input and result valid/ready streams of the sum-of-products evaluator.
interface sop_logic_eval_if
  import sop_logic_eval_pkg::*;
#(
  parameter int unsigned N_IN = SOP_N_IN
);
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_x;
  logic            out_valid;
  logic            out_ready;
  logic            out_z;

  modport master (output in_valid, in_x, out_ready,
                  input  in_ready, out_valid, out_z);
  modport slave  (input  in_valid, in_x, out_ready,
                  output in_ready, out_valid, out_z);
endinterface

// File: rtl/sop_term_eval.sv
// Combinational evaluation: OR of masked product terms, gated by a masked product.
module sop_term_eval
  import sop_logic_eval_pkg::*;
#(
  parameter int unsigned N_IN   = SOP_N_IN,
  parameter int unsigned N_TERM = SOP_N_TERM,
  parameter bit          INVERT = 1'b0
) (
  input  logic [N_IN-1:0]        x,
  input  logic [N_TERM*N_IN-1:0] term_mask,
  input  logic [N_IN-1:0]        gate_mask,
  output logic                   z_c
);

  logic any_term_c;
  logic gate_ok_c;

  // A masked AND is true when every selected bit is set; an empty mask is true
  always_comb begin
    any_term_c = 1'b0;
    for (int unsigned t = 0; t < N_TERM; t++) begin
      any_term_c = any_term_c | (&(x | ~term_mask[t*N_IN +: N_IN]));
    end
    gate_ok_c = &(x | ~gate_mask);
    z_c       = (any_term_c & gate_ok_c) ^ INVERT;
  end

endmodule

// File: rtl/sop_logic_eval.sv
// Two-stage sum-of-products evaluator with writable masks and a saturating hit counter.
module sop_logic_eval
  import sop_logic_eval_pkg::*;
#(
  parameter int unsigned               N_IN          = SOP_N_IN,
  parameter int unsigned               N_TERM        = SOP_N_TERM,
  parameter int unsigned               CNT_W         = SOP_CNT_W,
  parameter logic [N_TERM*N_IN-1:0]    DEF_TERM_MASK = SOP_DEF_TERM_MASK,
  parameter logic [N_IN-1:0]           DEF_GATE_MASK = SOP_DEF_GATE_MASK,
  parameter bit                        INVERT        = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  sop_logic_eval_if.slave                    bus,
  input  logic                               cfg_we,
  input  logic [sop_clog2(N_TERM+1)-1:0]     cfg_addr,
  input  logic [N_IN-1:0]                    cfg_data,
  output logic                               cfg_err,
  input  logic                               cnt_clr,
  output logic [CNT_W-1:0]                   hit_cnt
);

  localparam int unsigned AW = sop_clog2(N_TERM + 1);

  logic                          s1_valid_q, s1_valid_d;
  logic [N_IN-1:0]               s1_x_q, s1_x_d;
  logic                          s2_valid_q, s2_valid_d;
  logic                          s2_z_q, s2_z_d;
  logic [N_TERM-1:0][N_IN-1:0]   term_mask_q, term_mask_d;
  logic [N_IN-1:0]               gate_mask_q, gate_mask_d;
  logic                          cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]              hit_cnt_q, hit_cnt_d;

  logic in_ready_c;
  logic s1_take_c;
  logic s2_take_c;
  logic deliver_c;
  logic cfg_ok_c;
  logic eval_z_c;

  sop_term_eval #(
    .N_IN   (N_IN),
    .N_TERM (N_TERM),
    .INVERT (INVERT)
  ) u_term_eval (
    .x         (s1_x_q),
    .term_mask (term_mask_q),
    .gate_mask (gate_mask_q),
    .z_c       (eval_z_c)
  );

  // s1 can only be blocked when both stages hold words and the result is stalled
  assign in_ready_c = !(s1_valid_q && s2_valid_q && !bus.out_ready);
  assign s1_take_c  = bus.in_valid && in_ready_c;
  assign s2_take_c  = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign deliver_c  = s2_valid_q && bus.out_ready;
  assign cfg_ok_c   = cfg_we && !s1_valid_q && !s2_valid_q && (cfg_addr <= AW'(N_TERM));

  // Next-state for pipeline, mask file, error pulse and hit counter
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s2_valid_d  = s2_valid_q;
    s2_z_d      = s2_z_q;
    term_mask_d = term_mask_q;
    gate_mask_d = gate_mask_q;
    cfg_err_d   = 1'b0;
    hit_cnt_d   = hit_cnt_q;

    if (s1_take_c) begin
      s1_valid_d = 1'b1;
      s1_x_d     = bus.in_x;
    end else if (s2_take_c) begin
      s1_valid_d = 1'b0;
    end

    if (s2_take_c) begin
      s2_valid_d = 1'b1;
      s2_z_d     = eval_z_c;
    end else if (deliver_c) begin
      s2_valid_d = 1'b0;
    end

    if (cfg_ok_c) begin
      if (cfg_addr == AW'(N_TERM)) begin
        gate_mask_d = cfg_data;
      end
      for (int unsigned t = 0; t < N_TERM; t++) begin
        if (cfg_addr == AW'(t)) term_mask_d[t] = cfg_data;
      end
    end
    cfg_err_d = cfg_we && !cfg_ok_c;

    // Clear beats a same-cycle hit; the counter sticks at all-ones
    if (cnt_clr) begin
      hit_cnt_d = '0;
    end else if (deliver_c && s2_z_q && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_z_q      <= 1'b0;
      term_mask_q <= DEF_TERM_MASK;
      gate_mask_q <= DEF_GATE_MASK;
      cfg_err_q   <= 1'b0;
      hit_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s2_valid_q  <= s2_valid_d;
      s2_z_q      <= s2_z_d;
      term_mask_q <= term_mask_d;
      gate_mask_q <= gate_mask_d;
      cfg_err_q   <= cfg_err_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_z     = s2_z_q;
  assign cfg_err       = cfg_err_q;
  assign hit_cnt       = hit_cnt_q;

endmodule

// File: tb/tb_sop_logic_eval.sv
// Randomized and directed checks of sop_logic_eval against a word-level reference model.
module tb_sop_logic_eval;
  import sop_logic_eval_pkg::*;

  localparam int unsigned N_IN   = 4;
  localparam int unsigned N_TERM = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [N_IN-1:0]  cfg_data;
  logic             cfg_err;
  logic             cnt_clr;
  logic [CNT_W-1:0] hit_cnt;

  always #5 clk = ~clk;

  sop_logic_eval_if #(.N_IN(N_IN)) bus ();

  sop_logic_eval #(
    .N_IN   (N_IN),
    .N_TERM (N_TERM),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err),
    .cnt_clr  (cnt_clr),
    .hit_cnt  (hit_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: masks, in-flight words (result + acceptance edge), counter
  logic [N_IN-1:0] m_term [N_TERM];
  logic [N_IN-1:0] m_gate;
  bit              q_z [$];
  int              q_t [$];
  int              edge_cnt = 0;
  int              m_cnt;
  bit              m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit prod_true(input logic [N_IN-1:0] x, input logic [N_IN-1:0] m);
    for (int i = 0; i < N_IN; i++) begin
      if (m[i] && !x[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit ref_z(input logic [N_IN-1:0] x);
    bit any;
    any = 1'b0;
    for (int t = 0; t < N_TERM; t++) begin
      if (prod_true(x, m_term[t])) any = 1'b1;
    end
    return any && prod_true(x, m_gate);
  endfunction

  task automatic model_reset();
    m_term[0] = 4'h3;
    m_term[1] = 4'hC;
    m_gate    = 4'hA;
    q_z.delete();
    q_t.delete();
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs, advance the model across the edge
  task automatic step(input bit v, input logic [N_IN-1:0] x, input bit ordy,
                      input bit we, input logic [1:0] a, input logic [N_IN-1:0] d,
                      input bit clr);
    bit exp_ov, exp_rdy, acc, dlv, wr_ok;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_x      = x;
    bus.out_ready = ordy;
    cfg_we        = we;
    cfg_addr      = a;
    cfg_data      = d;
    cnt_clr       = clr;
    #1;
    exp_ov  = (q_t.size() > 0) && (edge_cnt >= q_t[0] + 1);
    exp_rdy = !((q_t.size() == 2) && !ordy);
    check_eq("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (exp_ov) check_eq("out_z", 32'(bus.out_z), 32'(q_z[0]));
    check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
    check_eq("hit_cnt", 32'(hit_cnt), 32'(m_cnt));

    acc   = v && exp_rdy;
    dlv   = exp_ov && ordy;
    wr_ok = we && (q_t.size() == 0) && (a <= 2'(N_TERM));
    if (wr_ok) begin
      if (a == 2'(N_TERM)) m_gate = d;
      else m_term[a] = d;
    end
    m_err = we && !wr_ok;
    if (clr) m_cnt = 0;
    else if (dlv && q_z[0] && m_cnt < CNT_MAX) m_cnt++;
    if (dlv) begin
      void'(q_z.pop_front());
      void'(q_t.pop_front());
    end
    edge_cnt++;
    if (acc) begin
      q_z.push_back(ref_z(x));
      q_t.push_back(edge_cnt);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic put(input logic [N_IN-1:0] x);
    step(1'b1, x, 1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.out_ready = 1'b0;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_data     = '0;
    cnt_clr      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_z", 32'(bus.out_z), 32'd0);
    check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
    check_eq("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    rst_n = 1'b1;

    // Default masks, back-to-back words
    put(4'b1111); put(4'b0011); put(4'b1011); put(4'b1010);
    idle(3, 1'b1);
    #1 check_eq("hits_default", 32'(hit_cnt), 32'd2);

    // Backpressure: two words fill the pipe, the rest wait
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, '0, '0, 1'b0);
      if (i == 2) #1 check_eq("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    idle(4, 1'b1);

    // Gate mask cleared on an empty pipe, then 0011 evaluates true
    step(1'b0, '0, 1'b1, 1'b1, 2'd2, 4'h0, 1'b0);
    put(4'b0011);
    idle(2, 1'b1);
    // Write while a result is waiting is dropped
    step(1'b1, 4'b0101, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 2'd0, 4'hF, 1'b0);
    #1 check_eq("busy_write_err", 32'(cfg_err), 32'd1);
    idle(3, 1'b1);
    put(4'b0011);
    idle(2, 1'b1);

    // Out-of-range address
    step(1'b0, '0, 1'b1, 1'b1, 2'd3, 4'hF, 1'b0);
    #1 check_eq("bad_addr_err", 32'(cfg_err), 32'd1);
    idle(1, 1'b1);
    #1 check_eq("bad_addr_err_pulse", 32'(cfg_err), 32'd0);
    put(4'b1010); put(4'b0100);
    idle(2, 1'b1);

    // Counter saturation, then clear against a same-cycle hit
    step(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 5; i++) put(4'b1111);
    idle(3, 1'b1);
    #1 check_eq("hit_saturate", 32'(hit_cnt), 32'(CNT_MAX));
    put(4'b1111);
    idle(1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
    #1 check_eq("clr_wins", 32'(hit_cnt), 32'd0);

    // Reset with both stages occupied
    step(1'b1, 4'b1111, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 4'b1011, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_out_z", 32'(bus.out_z), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    put(4'b0011); put(4'b1011);
    idle(2, 1'b1);

    // Randomized traffic, backpressure, config writes and clears
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0),
           2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 31) == 0));
    end
    idle(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
